// File: rtl/ndn_pkg.sv
// ---------------------------------------------------------------------------
// ndn_pkg
// Shared widths and types for the NDN forwarding blocks (PIT / FIB).
//   PREFIX_W    : name prefix width
//   LEN_W       : prefix length field width
//   BYTE_W      : Data stream byte width
//   pit_state_t : PIT controller states
//   pit_entry_t : one PIT slot {valid, len, prefix}
// ---------------------------------------------------------------------------
package ndn_pkg;

    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 6;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        I_LOOK,
        I_FWD,
        Q_LOOK,
        Q_REPLY,
        XFER
    } pit_state_t;

    typedef struct packed {
        logic                valid;
        logic [LEN_W-1:0]    len;
        logic [PREFIX_W-1:0] prefix;
    } pit_entry_t;

endpackage

// File: rtl/pit_cam.sv
// ---------------------------------------------------------------------------
// pit_cam
// Fully associative PIT entry store with a parallel exact-match search on
// {len, prefix} and a lowest-index free-slot finder.
//   clk, rst               : clock, synchronous active-low reset (clears valid bits)
//   key_prefix, key_len    : search key
//   hit, hit_idx           : key matches a valid entry, and which one
//   free, free_idx         : at least one slot is empty, lowest empty index
//   wr_en, wr_idx,
//   wr_prefix, wr_len      : install a new valid entry
//   inv_en, inv_idx        : retire an entry
// ---------------------------------------------------------------------------
module pit_cam
    import ndn_pkg::*;
#(
    parameter  int NUM_ENTRIES = 8,
    localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PREFIX_W-1:0] key_prefix,
    input  logic [LEN_W-1:0]    key_len,
    output logic                hit,
    output logic [IDX_W-1:0]    hit_idx,
    output logic                free,
    output logic [IDX_W-1:0]    free_idx,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [PREFIX_W-1:0] wr_prefix,
    input  logic [LEN_W-1:0]    wr_len,
    input  logic                inv_en,
    input  logic [IDX_W-1:0]    inv_idx
);

    pit_entry_t entries [NUM_ENTRIES];

    // Only the valid bits carry state across reset; len/prefix of an
    // invalid slot are never looked at.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (wr_en) begin
                entries[wr_idx] <= '{valid: 1'b1, len: wr_len, prefix: wr_prefix};
            end
            if (inv_en) begin
                entries[inv_idx].valid <= 1'b0;
            end
        end
    end

    // Scan high-to-low so the last assignment wins with the lowest index.
    // Duplicates never exist, so at most one entry can match.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (entries[i].valid && entries[i].len == key_len &&
                entries[i].prefix == key_prefix) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!entries[i].valid) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pit_table.sv
// ---------------------------------------------------------------------------
// pit_table
// Pending Interest Table. Records outstanding Interests, forwards new ones to
// the FIB, answers the FIB's Data query and streams matching Data out.
//   clk, rst                        : clock, synchronous active-low reset
//   int_valid/int_prefix/int_len    : incoming Interest
//   int_ready, int_drop             : Interest accepted / discarded (table full)
//   pit_in_prefix/pit_in_len,
//   fib_out_bit                     : forward request to the FIB (1-cycle pulse)
//   fib_prefix_ready/fib_prefix/
//   fib_len                         : FIB Data query
//   fib_data                        : FIB Data byte stream
//   start_send_to_pit, rejected     : query answer pulses
//   data_out/data_out_valid/
//   data_out_last                   : Data stream toward the requesting face
//   occupancy                       : number of valid entries
// ---------------------------------------------------------------------------
module pit_table
    import ndn_pkg::*;
#(
    parameter  int NUM_ENTRIES = 8,
    parameter  int DATA_BYTES  = 1024,
    localparam int OCC_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                int_valid,
    input  logic [PREFIX_W-1:0] int_prefix,
    input  logic [LEN_W-1:0]    int_len,
    output logic                int_ready,
    output logic                int_drop,
    output logic [PREFIX_W-1:0] pit_in_prefix,
    output logic [LEN_W-1:0]    pit_in_len,
    output logic                fib_out_bit,
    input  logic                fib_prefix_ready,
    input  logic [PREFIX_W-1:0] fib_prefix,
    input  logic [LEN_W-1:0]    fib_len,
    input  logic [BYTE_W-1:0]   fib_data,
    output logic                start_send_to_pit,
    output logic                rejected,
    output logic [BYTE_W-1:0]   data_out,
    output logic                data_out_valid,
    output logic                data_out_last,
    output logic [OCC_W-1:0]    occupancy
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CNT_W = $clog2(DATA_BYTES + 1);

    pit_state_t          state;
    logic                query_pend;
    logic [PREFIX_W-1:0] q_prefix;
    logic [LEN_W-1:0]    q_len;
    logic [PREFIX_W-1:0] i_prefix;
    logic [LEN_W-1:0]    i_len;
    logic [IDX_W-1:0]    match_idx;
    logic [CNT_W-1:0]    byte_cnt;

    logic [PREFIX_W-1:0] key_prefix;
    logic [LEN_W-1:0]    key_len;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                free;
    logic [IDX_W-1:0]    free_idx;
    logic                wr_en;
    logic                inv_en;
    logic                q_capture;

    // The query strobe can be a single cycle, so it is latched whenever the
    // query path is not itself busy with an earlier query or transfer.
    assign q_capture = fib_prefix_ready &&
                       !(state inside {Q_LOOK, Q_REPLY, XFER});

    // A pending or arriving query takes priority over a new Interest.
    assign int_ready = rst && (state == IDLE) && !query_pend && !fib_prefix_ready;

    assign key_prefix = (state == Q_LOOK) ? q_prefix : i_prefix;
    assign key_len    = (state == Q_LOOK) ? q_len    : i_len;

    assign wr_en  = (state == I_LOOK) && !hit && free;
    assign inv_en = (state == Q_REPLY) && start_send_to_pit;

    pit_cam #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_cam (
        .clk        (clk),
        .rst        (rst),
        .key_prefix (key_prefix),
        .key_len    (key_len),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .free       (free),
        .free_idx   (free_idx),
        .wr_en      (wr_en),
        .wr_idx     (free_idx),
        .wr_prefix  (i_prefix),
        .wr_len     (i_len),
        .inv_en     (inv_en),
        .inv_idx    (match_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            query_pend        <= 1'b0;
            int_drop          <= 1'b0;
            fib_out_bit       <= 1'b0;
            pit_in_prefix     <= '0;
            pit_in_len        <= '0;
            start_send_to_pit <= 1'b0;
            rejected          <= 1'b0;
            data_out          <= '0;
            data_out_valid    <= 1'b0;
            data_out_last     <= 1'b0;
            byte_cnt          <= '0;
            occupancy         <= '0;
        end else begin
            // Every registered output is a pulse or a per-state value;
            // default low and let the state below raise it.
            int_drop          <= 1'b0;
            fib_out_bit       <= 1'b0;
            pit_in_prefix     <= '0;
            pit_in_len        <= '0;
            start_send_to_pit <= 1'b0;
            rejected          <= 1'b0;
            data_out          <= '0;
            data_out_valid    <= 1'b0;
            data_out_last     <= 1'b0;

            if (q_capture) begin
                q_prefix   <= fib_prefix;
                q_len      <= fib_len;
                query_pend <= 1'b1;
            end

            // Insert and invalidate occur in different states, never together.
            if (wr_en) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (inv_en) begin
                occupancy <= occupancy - OCC_W'(1);
            end

            case (state)
                IDLE: begin
                    if (query_pend || fib_prefix_ready) begin
                        state <= Q_LOOK;
                    end else if (int_valid) begin
                        i_prefix <= int_prefix;
                        i_len    <= int_len;
                        state    <= I_LOOK;
                    end
                end
                I_LOOK: begin
                    if (hit) begin
                        // Already pending: aggregate, nothing to forward.
                        state <= IDLE;
                    end else if (free) begin
                        fib_out_bit   <= 1'b1;
                        pit_in_prefix <= i_prefix;
                        pit_in_len    <= i_len;
                        state         <= I_FWD;
                    end else begin
                        int_drop <= 1'b1;
                        state    <= IDLE;
                    end
                end
                I_FWD: begin
                    state <= IDLE;
                end
                Q_LOOK: begin
                    query_pend        <= 1'b0;
                    match_idx         <= hit_idx;
                    start_send_to_pit <= hit;
                    rejected          <= !hit;
                    state             <= Q_REPLY;
                end
                Q_REPLY: begin
                    if (start_send_to_pit) begin
                        byte_cnt <= '0;
                        state    <= XFER;
                    end else begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    data_out       <= fib_data;
                    data_out_valid <= 1'b1;
                    byte_cnt       <= byte_cnt + CNT_W'(1);
                    if (byte_cnt == CNT_W'(DATA_BYTES - 1)) begin
                        data_out_last <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pit_table.sv
// ---------------------------------------------------------------------------
// tb_pit_table
// Directed bench for pit_table: Interest forwarding, aggregation, table-full
// drop, query hit/miss with the full Data stream, query latching during the
// Interest path, query/Interest tie, and reset in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_pit_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_valid;
    logic [63:0] int_prefix;
    logic [5:0]  int_len;
    logic        int_ready;
    logic        int_drop;
    logic [63:0] pit_in_prefix;
    logic [5:0]  pit_in_len;
    logic        fib_out_bit;
    logic        fib_prefix_ready;
    logic [63:0] fib_prefix;
    logic [5:0]  fib_len;
    logic [7:0]  fib_data;
    logic        start_send_to_pit;
    logic        rejected;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_last;
    logic [3:0]  occupancy;

    localparam logic [63:0] PFX_A = 64'hDEAD_0000_0000_0000;
    localparam logic [63:0] PFX_X = 64'hCAFE_F00D_0000_0009;
    localparam logic [63:0] PFX_J = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PFX_K = 64'h5555_AAAA_0000_1111;

    int checks    = 0;
    int failures  = 0;
    int fwd_cnt   = 0;
    int drop_cnt  = 0;
    int start_cnt = 0;
    int rej_cnt   = 0;
    int last_cnt  = 0;
    logic [63:0] fwd_prefix = '0;

    always #5 clk = ~clk;

    pit_table #(
        .NUM_ENTRIES(8),
        .DATA_BYTES (1024)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .int_valid         (int_valid),
        .int_prefix        (int_prefix),
        .int_len           (int_len),
        .int_ready         (int_ready),
        .int_drop          (int_drop),
        .pit_in_prefix     (pit_in_prefix),
        .pit_in_len        (pit_in_len),
        .fib_out_bit       (fib_out_bit),
        .fib_prefix_ready  (fib_prefix_ready),
        .fib_prefix        (fib_prefix),
        .fib_len           (fib_len),
        .fib_data          (fib_data),
        .start_send_to_pit (start_send_to_pit),
        .rejected          (rejected),
        .data_out          (data_out),
        .data_out_valid    (data_out_valid),
        .data_out_last     (data_out_last),
        .occupancy         (occupancy)
    );

    // Pulse counters sampled mid-cycle; a pulse wider than one cycle counts twice.
    always @(negedge clk) begin
        if (fib_out_bit) begin
            fwd_cnt++;
            fwd_prefix = pit_in_prefix;
        end
        if (int_drop)          drop_cnt++;
        if (start_send_to_pit) start_cnt++;
        if (rejected)          rej_cnt++;
        if (data_out_last)     last_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_interest(input logic [63:0] p, input logic [5:0] l);
        bit acc = 1'b0;
        int_valid  = 1'b1;
        int_prefix = p;
        int_len    = l;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = int_ready;
            @(posedge clk);
            #1;
        end
        int_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL interest_accept: int_ready never seen for %h", p);
        end
        step(3);
    endtask

    task automatic send_query(input logic [63:0] p, input logic [5:0] l);
        fib_prefix_ready = 1'b1;
        fib_prefix       = p;
        fib_len          = l;
        step(1);
        fib_prefix_ready = 1'b0;
    endtask

    // Returns at the negedge of the cycle carrying start_send_to_pit.
    task automatic wait_start(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = start_send_to_pit;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s: start_send_to_pit not seen within 10 cycles", name);
        end
    endtask

    // FIB drives byte k in the k-th cycle after start_send_to_pit; byte k must
    // appear on data_out one cycle later.
    task automatic run_xfer(input int stop_at, output int bad, output int nvalid,
                            output int last_at);
        bad     = 0;
        nvalid  = 0;
        last_at = -1;
        for (int k = 0; k <= stop_at; k++) begin
            @(posedge clk);
            #1;
            fib_data = 8'(k);
            @(negedge clk);
            if (k > 0) begin
                if (data_out_valid) nvalid++;
                if (!data_out_valid || data_out !== 8'(k - 1)) bad++;
                if (data_out_last) last_at = k - 1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step(3);
        @(negedge clk);
        checks++;
        if (int_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_int_ready: got %b want 0", int_ready);
        end
        checks++;
        if (occupancy !== 4'd0) begin
            failures++;
            $display("FAIL reset_occupancy: got %0d want 0", occupancy);
        end
        checks++;
        if ({fib_out_bit, int_drop, start_send_to_pit, rejected,
             data_out_valid, data_out_last} !== 6'b0 || data_out !== 8'h00 ||
            pit_in_prefix !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero");
        end
        step(1);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (int_ready !== 1'b1) begin
            failures++;
            $display("FAIL first_idle_int_ready: got %b want 1", int_ready);
        end
        step(1);
    endtask

    task automatic test_interest_fwd;
        int_valid  = 1'b1;
        int_prefix = PFX_A;
        int_len    = 6'd16;
        @(negedge clk);
        checks++;
        if (int_ready !== 1'b1) begin
            failures++;
            $display("FAIL fwd_int_ready: got %b want 1", int_ready);
        end
        step(1);
        int_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fib_out_bit !== 1'b0) begin
            failures++;
            $display("FAIL fwd_early: fib_out_bit got %b want 0", fib_out_bit);
        end
        step(1);
        @(negedge clk);
        checks++;
        if (fib_out_bit !== 1'b1 || pit_in_prefix !== PFX_A || pit_in_len !== 6'd16) begin
            failures++;
            $display("FAIL fwd_pulse: bit=%b prefix=%h len=%0d want 1 %h 16",
                     fib_out_bit, pit_in_prefix, pit_in_len, PFX_A);
        end
        checks++;
        if (occupancy !== 4'd1) begin
            failures++;
            $display("FAIL fwd_occupancy: got %0d want 1", occupancy);
        end
        step(1);
        @(negedge clk);
        checks++;
        if (fib_out_bit !== 1'b0 || pit_in_prefix !== 64'h0) begin
            failures++;
            $display("FAIL fwd_pulse_end: bit=%b prefix=%h want 0 0", fib_out_bit, pit_in_prefix);
        end
        step(1);
    endtask

    task automatic test_aggregate;
        int f0 = fwd_cnt;
        send_interest(PFX_A, 6'd16);
        checks++;
        if (fwd_cnt !== f0) begin
            failures++;
            $display("FAIL aggregate_fwd: forwards got %0d want %0d", fwd_cnt, f0);
        end
        checks++;
        if (occupancy !== 4'd1) begin
            failures++;
            $display("FAIL aggregate_occupancy: got %0d want 1", occupancy);
        end
    endtask

    task automatic test_full;
        int f0 = fwd_cnt;
        int d0 = drop_cnt;
        for (int i = 1; i <= 7; i++) begin
            send_interest({16'hBEEF, 48'(i)}, 6'd24);
        end
        checks++;
        if (occupancy !== 4'd8 || fwd_cnt !== f0 + 7) begin
            failures++;
            $display("FAIL fill_table: occupancy=%0d forwards=%0d want 8 %0d",
                     occupancy, fwd_cnt - f0, 7);
        end
        send_interest(PFX_X, 6'd32);
        checks++;
        if (drop_cnt !== d0 + 1) begin
            failures++;
            $display("FAIL full_drop: drop cycles got %0d want 1", drop_cnt - d0);
        end
        checks++;
        if (fwd_cnt !== f0 + 7) begin
            failures++;
            $display("FAIL full_no_fwd: forwards got %0d want 7", fwd_cnt - f0);
        end
        checks++;
        if (occupancy !== 4'd8) begin
            failures++;
            $display("FAIL full_occupancy: got %0d want 8", occupancy);
        end
    endtask

    task automatic test_query_hit;
        int s0 = start_cnt;
        int r0 = rej_cnt;
        int l0 = last_cnt;
        int bad, nvalid, last_at;
        send_query(PFX_A, 6'd16);
        wait_start("query_a_start");
        run_xfer(1024, bad, nvalid, last_at);
        checks++;
        if (bad !== 0 || nvalid !== 1024) begin
            failures++;
            $display("FAIL stream_bytes: bad=%0d valid=%0d want 0 1024", bad, nvalid);
        end
        checks++;
        if (last_at !== 1023) begin
            failures++;
            $display("FAIL stream_last: last on byte %0d want 1023", last_at);
        end
        step(1);
        @(negedge clk);
        checks++;
        if (data_out_valid !== 1'b0 || data_out_last !== 1'b0) begin
            failures++;
            $display("FAIL stream_end: valid=%b last=%b want 0 0", data_out_valid, data_out_last);
        end
        checks++;
        if (occupancy !== 4'd7) begin
            failures++;
            $display("FAIL hit_occupancy: got %0d want 7", occupancy);
        end
        step(1);
        checks++;
        if (start_cnt !== s0 + 1 || rej_cnt !== r0 || last_cnt !== l0 + 1) begin
            failures++;
            $display("FAIL hit_pulses: start=%0d rej=%0d last=%0d want 1 0 1",
                     start_cnt - s0, rej_cnt - r0, last_cnt - l0);
        end
        send_query(PFX_A, 6'd16);
        step(4);
        checks++;
        if (rej_cnt !== r0 + 1 || start_cnt !== s0 + 1) begin
            failures++;
            $display("FAIL repeat_reject: rej=%0d start=%0d want 1 1",
                     rej_cnt - r0, start_cnt - s0);
        end
    endtask

    task automatic test_query_during_fwd;
        int bad, nvalid, last_at;
        int_valid  = 1'b1;
        int_prefix = PFX_J;
        int_len    = 6'd40;
        step(1);
        int_valid = 1'b0;
        step(1);
        @(negedge clk);
        checks++;
        if (fib_out_bit !== 1'b1) begin
            failures++;
            $display("FAIL ifwd_cycle: fib_out_bit got %b want 1", fib_out_bit);
        end
        fib_prefix_ready = 1'b1;
        fib_prefix       = {16'hBEEF, 48'd1};
        fib_len          = 6'd24;
        step(1);
        fib_prefix_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (int_ready !== 1'b0) begin
            failures++;
            $display("FAIL pend_int_ready: got %b want 0", int_ready);
        end
        wait_start("latched_query_start");
        run_xfer(1024, bad, nvalid, last_at);
        checks++;
        if (bad !== 0 || last_at !== 1023) begin
            failures++;
            $display("FAIL latched_stream: bad=%0d last=%0d want 0 1023", bad, last_at);
        end
        step(1);
        checks++;
        if (occupancy !== 4'd7) begin
            failures++;
            $display("FAIL latched_occupancy: got %0d want 7", occupancy);
        end
    endtask

    task automatic test_back_to_back;
        int s0 = start_cnt;
        int f0;
        int bad, nvalid, last_at;
        int_valid        = 1'b1;
        int_prefix       = PFX_K;
        int_len          = 6'd12;
        fib_prefix_ready = 1'b1;
        fib_prefix       = {16'hBEEF, 48'd2};
        fib_len          = 6'd24;
        @(negedge clk);
        checks++;
        if (int_ready !== 1'b0) begin
            failures++;
            $display("FAIL tie_int_ready: got %b want 0", int_ready);
        end
        step(1);
        int_valid        = 1'b0;
        fib_prefix_ready = 1'b0;
        wait_start("tie_query_start");
        run_xfer(1024, bad, nvalid, last_at);
        step(1);
        checks++;
        if (start_cnt !== s0 + 1 || occupancy !== 4'd6) begin
            failures++;
            $display("FAIL tie_query_first: start=%0d occupancy=%0d want 1 6",
                     start_cnt - s0, occupancy);
        end
        f0 = fwd_cnt;
        send_interest(PFX_K, 6'd12);
        checks++;
        if (fwd_cnt !== f0 + 1 || fwd_prefix !== PFX_K || occupancy !== 4'd7) begin
            failures++;
            $display("FAIL tie_interest_after: fwd=%0d prefix=%h occupancy=%0d want 1 %h 7",
                     fwd_cnt - f0, fwd_prefix, occupancy, PFX_K);
        end
    endtask

    task automatic test_reset_mid_xfer;
        int l0 = last_cnt;
        int f0;
        int bad, nvalid, last_at;
        send_query({16'hBEEF, 48'd3}, 6'd24);
        wait_start("mid_query_start");
        run_xfer(500, bad, nvalid, last_at);
        checks++;
        if (bad !== 0 || nvalid !== 500) begin
            failures++;
            $display("FAIL mid_stream: bad=%0d valid=%0d want 0 500", bad, nvalid);
        end
        rst = 1'b0;
        step(2);
        @(negedge clk);
        checks++;
        if (data_out_valid !== 1'b0 || data_out_last !== 1'b0 || data_out !== 8'h00 ||
            start_send_to_pit !== 1'b0 || fib_out_bit !== 1'b0 || int_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs: valid=%b last=%b data=%h ready=%b want all 0",
                     data_out_valid, data_out_last, data_out, int_ready);
        end
        checks++;
        if (occupancy !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset_occupancy: got %0d want 0", occupancy);
        end
        step(1);
        rst = 1'b1;
        step(1);
        checks++;
        if (last_cnt !== l0) begin
            failures++;
            $display("FAIL mid_reset_no_last: last pulses got %0d want 0", last_cnt - l0);
        end
        f0 = fwd_cnt;
        send_interest(PFX_A, 6'd16);
        checks++;
        if (fwd_cnt !== f0 + 1 || fwd_prefix !== PFX_A || occupancy !== 4'd1) begin
            failures++;
            $display("FAIL post_reset_fwd: fwd=%0d prefix=%h occupancy=%0d want 1 %h 1",
                     fwd_cnt - f0, fwd_prefix, occupancy, PFX_A);
        end
    endtask

    initial begin
        rst              = 1'b0;
        int_valid        = 1'b0;
        int_prefix       = '0;
        int_len          = '0;
        fib_prefix_ready = 1'b0;
        fib_prefix       = '0;
        fib_len          = '0;
        fib_data         = '0;
        step(1);
        test_reset;
        test_interest_fwd;
        test_aggregate;
        test_full;
        test_query_hit;
        test_query_during_fwd;
        test_back_to_back;
        test_reset_mid_xfer;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
